// File: rtl/rsa256_core.sv
// 256-bit modular exponentiation a^d mod n: right-to-left square-and-multiply
// over radix-2 bit-serial Montgomery products, after pre-scaling a by 2^256 mod n.
module rsa256_core (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [255:0] i_a,
  input  logic [255:0] i_d,
  input  logic [255:0] i_n,
  output logic [255:0] o_a_pow_d,
  output logic         o_finished
);

  typedef enum logic [2:0] {IDLE, PREP, MONT, CALC, DONE} state_t;

  state_t       state, state_nxt;
  logic [255:0] d_r, n_r, t, m;
  logic [257:0] acc1, acc2;
  logic [7:0]   cyc_cnt, bit_cnt;

  logic [257:0] n_ext, t2;
  logic [255:0] t2_red, p1, p2;

  // One radix-2 Montgomery iteration; stays below 2^258 even off-contract.
  function automatic logic [257:0] mp_step(input logic [257:0] acc,
                                           input logic [257:0] aop,
                                           input logic         b,
                                           input logic [257:0] n);
    logic [257:0] s;
    s = acc + (b ? aop : 258'd0);
    if (s[0]) s = s + n;
    return s >> 1;
  endfunction

  assign n_ext  = {2'b00, n_r};
  assign t2     = {1'b0, t, 1'b0};
  assign t2_red = 256'((t2 >= n_ext) ? t2 - n_ext : t2);
  assign p1     = 256'((acc1 >= n_ext) ? acc1 - n_ext : acc1);
  assign p2     = 256'((acc2 >= n_ext) ? acc2 - n_ext : acc2);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (i_start) state_nxt = PREP;
      PREP: if (cyc_cnt == 8'd255) state_nxt = MONT;
      MONT: if (cyc_cnt == 8'd255) state_nxt = CALC;
      CALC: state_nxt = (bit_cnt == 8'd255) ? DONE : MONT;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state      <= IDLE;
      d_r        <= '0;
      n_r        <= '0;
      t          <= '0;
      m          <= '0;
      acc1       <= '0;
      acc2       <= '0;
      cyc_cnt    <= '0;
      bit_cnt    <= '0;
      o_a_pow_d  <= '0;
      o_finished <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (i_start) begin
          d_r        <= i_d;
          n_r        <= i_n;
          t          <= i_a;
          m          <= 256'd1;
          acc1       <= '0;
          acc2       <= '0;
          cyc_cnt    <= '0;
          bit_cnt    <= '0;
          o_finished <= 1'b0;
        end
        PREP: begin
          t       <= t2_red;
          cyc_cnt <= cyc_cnt + 8'd1;
        end
        MONT: begin
          // P1 = MP(m,t), P2 = MP(t,t); both scan the bits of t.
          acc1    <= mp_step(acc1, {2'b00, m}, t[cyc_cnt], n_ext);
          acc2    <= mp_step(acc2, {2'b00, t}, t[cyc_cnt], n_ext);
          cyc_cnt <= cyc_cnt + 8'd1;
        end
        CALC: begin
          if (d_r[bit_cnt]) m <= p1;
          t       <= p2;
          acc1    <= '0;
          acc2    <= '0;
          bit_cnt <= bit_cnt + 8'd1;
        end
        DONE: begin
          o_a_pow_d  <= m;
          o_finished <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa256_core.sv
// Scoreboard bench for rsa256_core: expectations queued at start, checked on finish.
module tb_rsa256_core;

  logic         i_clk = 1'b0;
  logic         i_rst, i_start;
  logic [255:0] i_a, i_d, i_n, o_a_pow_d;
  logic         o_finished;

  rsa256_core dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
    .i_a(i_a), .i_d(i_d), .i_n(i_n),
    .o_a_pow_d(o_a_pow_d), .o_finished(o_finished)
  );

  always #5 i_clk = ~i_clk;

  localparam logic [255:0] BIG_N = 256'hca3586e7ea485f3b0a222a4c79f7dd12e85388eccdee4035940d774c029cf831;
  localparam logic [255:0] BIG_D = 256'hb6ace0b14720169839b15fd13326cf1a1829beafc37bb937bec8802fbcf46bd9;
  localparam logic [255:0] BIG_A = 256'hc6b662ecb173c53cc7bb4212057f9c0ba283e000b98c9dcf5feaee7d6c933dfb;
  localparam int LAT = 66050;

  typedef struct {
    logic [255:0] exp;
    int           t0;
    string        name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0, errors = 0, done_cnt = 0;
  logic fin_q = 1'b0;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s act=%h req=%h", nm, act, req);
    end
  endtask

  // Plain big-integer reference: square-and-multiply with 512-bit products.
  function automatic logic [255:0] modexp(input logic [255:0] a, input logic [255:0] d,
                                          input logic [255:0] n);
    logic [511:0] r, b, nn;
    nn = {256'd0, n};
    r  = 512'd1 % nn;
    b  = {256'd0, a} % nn;
    for (int i = 0; i < 256; i++) begin
      if (d[i]) r = (r * b) % nn;
      b = (b * b) % nn;
    end
    return r[255:0];
  endfunction

  always @(negedge i_clk) begin
    if (o_finished && !fin_q) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_finish act=1 req=0");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_result"}, o_a_pow_d, e.exp);
        chk({e.name, "_latency"}, 256'(cyc - e.t0), 256'(LAT));
        done_cnt++;
      end
    end
    fin_q = o_finished;
  end

  task automatic start_run(input logic [255:0] a, input logic [255:0] d, input logic [255:0] n,
                           input logic [255:0] exp, input string name);
    @(negedge i_clk);
    i_a = a; i_d = d; i_n = n; i_start = 1'b1;
    sb.push_back('{exp, cyc, name});
    @(negedge i_clk);
    i_start = 1'b0;
    chk({name, "_drop"}, {255'd0, o_finished}, 256'd0);
  endtask

  task automatic wait_done(input string name);
    int target;
    target = done_cnt + 1;
    for (int k = 0; k < 70000 && done_cnt < target; k++) @(negedge i_clk);
    if (done_cnt < target) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout act=no_finish req=finish", name);
      sb.delete();
    end
  endtask

  initial begin
    i_rst = 1'b0; i_start = 1'b0; i_a = '0; i_d = '0; i_n = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge i_clk);
      i_start = (c == 2);
      chk("rst_finished", {255'd0, o_finished}, 256'd0);
      chk("rst_result", o_a_pow_d, 256'd0);
    end
    @(negedge i_clk);
    i_start = 1'b0;
    i_rst = 1'b1;
    repeat (3) @(negedge i_clk);
    chk("idle_after_rst", {255'd0, o_finished}, 256'd0);

    // Small vector with mid-run operand changes and a stray start.
    start_run(256'd5, 256'd20, 256'd221, 256'd183, "small");
    repeat (1000) @(negedge i_clk);
    i_a = 256'd7; i_d = 256'd3; i_n = 256'd11; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    wait_done("small");
    repeat (10) @(negedge i_clk);
    chk("hold_finished", {255'd0, o_finished}, 256'd1);
    chk("hold_result", o_a_pow_d, 256'd183);

    start_run(BIG_A, BIG_D, BIG_N, modexp(BIG_A, BIG_D, BIG_N), "full256");
    wait_done("full256");

    start_run(256'd5, 256'd0, 256'd221, 256'd1, "d0");
    wait_done("d0");
    start_run(256'd5, 256'd1, 256'd221, 256'd5, "d1");
    wait_done("d1");
    // 5 has order 16 mod 221, so 5^(2^256-1) = 5^15 = 5^-1 = 177.
    start_run(256'd5, '1, 256'd221, 256'd177, "dones");
    wait_done("dones");
    start_run(256'd0, 256'd7, 256'd221, 256'd0, "a0");
    wait_done("a0");

    // Abort mid-run, then a fresh start.
    start_run(256'd5, 256'd20, 256'd221, 256'd183, "abort");
    repeat (500) @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    chk("abort_finished", {255'd0, o_finished}, 256'd0);
    chk("abort_result", o_a_pow_d, 256'd0);
    void'(sb.pop_back());
    repeat (3) @(negedge i_clk);
    i_rst = 1'b1;
    start_run(256'd5, 256'd20, 256'd221, 256'd183, "fresh");
    wait_done("fresh");

    repeat (5) @(negedge i_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rsa256_core.md
Name: rsa256_core

Overview:
- 256-bit RSA modular-exponentiation engine; computes o_a_pow_d = i_a^i_d mod i_n.
- Uses right-to-left square-and-multiply over bit-serial Montgomery products (radix 2, R = 2^256), preceded by a bit-serial pre-scaling of a into the Montgomery domain.
- Sits behind the RSA host/wrapper, which loads operands, pulses start and reads the result once finished is high.

Parameters:
- none; the width is fixed at 256 bits.

Ports:
- i_clk  in  1  system clock; all state updates on the rising edge.
- i_rst  in  1  reset; asynchronous and active-low (asserted when 0).
- i_start  in  1  start request; sampled only in IDLE.
- i_a  in  256  base; caller guarantees i_a < i_n.
- i_d  in  256  exponent.
- i_n  in  256  modulus; caller guarantees odd and > 1.
- o_a_pow_d  out  256  result a^d mod n.
- o_finished  out  1  result valid / done flag.

Behaviour:
- Reset (i_rst=0, async):
  - state=IDLE; o_a_pow_d=0; o_finished=0; all internal registers cleared.
  - Reset mid-operation aborts the computation; no partial result is exposed.
- IDLE:
  - On i_start=1: latch i_a, i_d and i_n into internal registers. Later input changes are ignored.
  - Set t=a, m=1, bit counter=0, o_finished=0; go to PREP.
  - i_start while not in IDLE is ignored.
- PREP: exactly 256 cycles; produces t = a*2^256 mod n.
  - Each cycle: t = 2t; if t >= n then t -= n.
  - Use 258-bit intermediates.
  - Then go to MONT.
- MONT: exactly 256 cycles; two Montgomery products computed in parallel, P1 = MP(m,t) and P2 = MP(t,t).
  - Per product, per cycle i = 0..255: if b[i], acc += a_operand; if acc is odd, acc += n; acc = acc >> 1.
  - acc is 258 bits wide and starts at 0.
  - Then go to CALC.
- CALC: 1 cycle.
  - Final conditional subtract: if acc >= n then acc -= n, for both P1 and P2.
  - If d[counter]=1 then m = P1. Always t = P2.
  - counter += 1.
  - If counter reaches 256, go to DONE; otherwise go back to MONT.
- DONE: 1 cycle.
  - o_a_pow_d = m; o_finished = 1; go to IDLE.
- o_finished stays 1, and o_a_pow_d stays valid, until the next accepted i_start, which clears o_finished the following cycle.
- Latency, from the i_start sampling edge to o_finished=1: 1 + 256 + 256*(256+1) + 1 = 66050 cycles. This is fixed and data-independent.
- Arithmetic invariants:
  - m stays in the normal domain; t stays in the Montgomery domain; both are always < n after CALC.
  - The right-to-left scan means d bit 0 is processed first.
- Edge cases:
  - d = 0 gives 1.
  - a = 0 gives 0, except d = 0, which gives 1.
  - d = 1 gives a.
  - Operands with a >= n or even n are out of contract; the result is undefined, but the FSM must still terminate with the same latency.

Test Plan:
- Reset: hold i_rst=0 for 5 cycles, with i_start pulsed during reset -> o_finished=0, o_a_pow_d=0, no start accepted.
- Small vector: a=5, n=221, d=20, one-cycle i_start -> o_finished=1 exactly 66050 cycles after the start edge; o_a_pow_d=183; the flag stays high while idle.
- Full 256-bit vector:
  - n=0xca3586e7ea485f3b0a222a4c79f7dd12e85388eccdee4035940d774c029cf831
  - d=0xb6ace0b147201698 39b15fd13326cf1a1829beafc37bb937bec8802fbcf46bd9 (no space in the actual value)
  - a=0xc6b662ecb173c53cc7bb4212057f9c0ba283e000b98c9dcf5fea ee7d6c933dfb (no space in the actual value)
  - Required: o_finished=1 within 70000 cycles; result matches a golden big-integer pow(a,d,n).
- Edge exponents with n=221, a=5:
  - d=0 -> 1.
  - d=1 -> 5.
  - d=0xFF..FF (all ones) -> pow(5, 2^256-1, 221) per the golden model.
  - a=0, d=7 -> 0.
- Busy/abort:
  - Change i_a, i_d and i_n and re-pulse i_start mid-run -> result unchanged (183 for the small vector).
  - Assert i_rst=0 mid-run -> outputs clear immediately; a subsequent fresh start yields the correct result.
- Back-to-back: a second start after finished -> o_finished drops within 1 cycle, then rises with the new result after 66050 cycles.
